serial_subtractor_4bit: RTL and testbench

- Bit-serial four-bit subtractor; the inverse operation of the team's ripple-carry four-bit adder.
- Computes D = a - b - B_in, with borrow-out B_out, processing one bit per clock, LSB first.
- Uses a start/busy/done handshake so a sequencer can issue operands and collect the difference and borrow.
- Sits beside the adder in the arithmetic datapath and shares its operand buses.

---
 rtl/serial_subtractor_4bit.sv | 118 +++++++++++
 tb/tb_serial_subtractor_4bit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_4bit.sv
// Bit-serial subtractor: D = a - b - B_in, one bit per clock, LSB first.
// start/busy/done handshake; D and B_out update only on completion.
module serial_subtractor_4bit #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             B_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] D,
   output logic             B_out
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_borrow;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_D;
   logic             r_Bout;

   logic             w_x;
   logic             w_y;
   logic             w_diff;
   logic             w_borrow_nxt;
   logic             w_last;
   logic             w_load;
   logic             w_step;

   assign w_x          = r_a[0];
   assign w_y          = r_b[0];
   assign w_diff       = w_x ^ w_y ^ r_borrow;
   assign w_borrow_nxt = (~w_x & w_y) | (~(w_x ^ w_y) & r_borrow);
   assign w_last       = (r_cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt = SHIFT;
               w_load      = 1'b1;
            end
         end
         SHIFT: begin
            w_step = 1'b1;
            if (w_last) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            if (start) begin
               w_state_nxt = SHIFT;
               w_load      = 1'b1;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // r_a doubles as the result register: difference bits enter at the MSB
   // as minuend bits leave at the LSB.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_borrow <= 1'b0;
         r_cnt    <= '0;
         r_D      <= '0;
         r_Bout   <= 1'b0;
      end else if (w_load) begin
         r_a      <= a;
         r_b      <= b;
         r_borrow <= B_in;
         r_cnt    <= '0;
      end else if (w_step) begin
         r_a      <= {w_diff, r_a[WIDTH-1:1]};
         r_b      <= {1'b0, r_b[WIDTH-1:1]};
         r_borrow <= w_borrow_nxt;
         r_cnt    <= r_cnt + 1'b1;
         if (w_last) begin
            r_D    <= {w_diff, r_a[WIDTH-1:1]};
            r_Bout <= w_borrow_nxt;
         end
      end
   end

   assign busy  = (r_state == SHIFT);
   assign done  = (r_state == DONE);
   assign D     = r_D;
   assign B_out = r_Bout;

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// Directed bench for serial_subtractor_4bit: hand-computed vectors,
// handshake timing, ignored start, mid-op reset, continuous start.
module tb_serial_subtractor_4bit;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] a;
   logic [3:0] b;
   logic       B_in;
   logic       busy;
   logic       done;
   logic [3:0] D;
   logic       B_out;

   int n_checks;
   int n_pass;

   serial_subtractor_4bit #(.WIDTH(4)) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .a    (a),
      .b    (b),
      .B_in (B_in),
      .busy (busy),
      .done (done),
      .D    (D),
      .B_out(B_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One operation; sample i=0 is the negedge right after the accepting edge.
   task automatic do_op(input logic [3:0] a_i, input logic [3:0] b_i,
                        input logic bin_i, output int nbusy,
                        output int ndone, output int dpos,
                        output logic [3:0] d_o, output logic bo_o);
      @(negedge clk);
      a = a_i; b = b_i; B_in = bin_i; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = ~a_i; b = ~b_i; B_in = ~bin_i;
      nbusy = 0; ndone = 0; dpos = -1;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) @(negedge clk);
         if (busy) nbusy++;
         if (done) begin
            ndone++;
            dpos = i;
         end
      end
      d_o  = D;
      bo_o = B_out;
   endtask

   task automatic check_op(input string name, input logic [3:0] a_i,
                           input logic [3:0] b_i, input logic bin_i,
                           input logic [3:0] d_exp, input logic bo_exp);
      int nb, nd, dp;
      logic [3:0] dv;
      logic bo;
      do_op(a_i, b_i, bin_i, nb, nd, dp, dv, bo);
      n_checks++;
      if (dv !== d_exp)
         $display("FAIL %s D: got %0d want %0d", name, dv, d_exp);
      else n_pass++;
      n_checks++;
      if (bo !== bo_exp)
         $display("FAIL %s B_out: got %0b want %0b", name, bo, bo_exp);
      else n_pass++;
      n_checks++;
      if (nb != 4)
         $display("FAIL %s busy cycles: got %0d want 4", name, nb);
      else n_pass++;
      n_checks++;
      if (nd != 1 || dp != 4)
         $display("FAIL %s done: got %0d pulses at %0d want 1 at 4",
                  name, nd, dp);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; a = '0; b = '0; B_in = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({busy, done, D, B_out} !== 7'b0)
         $display("FAIL reset outs: got %b want 0", {busy, done, D, B_out});
      else n_pass++;
      // start coincident with reset: nothing must be captured
      start = 1'b1; a = 4'd7; b = 4'd1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0)
         $display("FAIL rst_with_start: got busy=%b done=%b want 0 0",
                  busy, done);
      else n_pass++;
   endtask

   task automatic test_vectors();
      check_op("zero", 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
      check_op("3-8-1", 4'd3, 4'd8, 1'b1, 4'd10, 1'b1);
      check_op("11-3", 4'd11, 4'd3, 1'b0, 4'd8, 1'b0);
      check_op("5-4-1", 4'd5, 4'd4, 1'b1, 4'd0, 1'b0);
      check_op("0-15-1", 4'd0, 4'd15, 1'b1, 4'd0, 1'b1);
      check_op("15-15", 4'd15, 4'd15, 1'b0, 4'd0, 1'b0);
   endtask

   task automatic test_ignore_start();
      int nd;
      @(negedge clk);
      a = 4'd12; b = 4'd6; B_in = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      nd = 0;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) @(negedge clk);
         if (i == 1) begin
            a = 4'd1; b = 4'd9; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (done) nd++;
      end
      n_checks++;
      if (D !== 4'd6 || B_out !== 1'b0)
         $display("FAIL ignore D/B_out: got %0d/%0b want 6/0", D, B_out);
      else n_pass++;
      n_checks++;
      if (nd != 1)
         $display("FAIL ignore done pulses: got %0d want 1", nd);
      else n_pass++;
   endtask

   task automatic test_midop_reset();
      @(negedge clk);
      a = 4'd9; b = 4'd2; B_in = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || D !== 4'd6)
         $display("FAIL pre_reset: got busy=%b D=%0d want 1 6", busy, D);
      else n_pass++;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({busy, done, D, B_out} !== 7'b0)
         $display("FAIL midop_reset: got %b want 0", {busy, done, D, B_out});
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      check_op("9-2 after rst", 4'd9, 4'd2, 1'b0, 4'd7, 1'b0);
   endtask

   task automatic test_back_to_back();
      int nd, nb, bad;
      @(negedge clk);
      a = 4'd15; b = 4'd1; B_in = 1'b0; start = 1'b1;
      @(negedge clk);
      nd = 0; nb = 0; bad = 0;
      for (int i = 0; i < 15; i++) begin
         if (i > 0) @(negedge clk);
         if (busy) nb++;
         if (done) begin
            nd++;
            if ((i % 5) != 4 || D !== 4'd14 || B_out !== 1'b0 || busy)
               bad++;
         end else if (!busy) begin
            bad++;
         end
      end
      start = 1'b0;
      n_checks++;
      if (nd != 3)
         $display("FAIL b2b done pulses: got %0d want 3", nd);
      else n_pass++;
      n_checks++;
      if (nb != 12)
         $display("FAIL b2b busy cycles: got %0d want 12", nb);
      else n_pass++;
      n_checks++;
      if (bad != 0)
         $display("FAIL b2b cadence: got %0d bad samples want 0", bad);
      else n_pass++;
      repeat (3) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0)
         $display("FAIL b2b idle: got busy=%b done=%b want 0 0", busy, done);
      else n_pass++;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      test_reset();
      test_vectors();
      test_ignore_start();
      test_midop_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
